// File: rtl/svi_array_rr_collector_pkg.sv
// ---------------------------------------------------------------------------
// svi_collect_pkg
// Shared definitions for the SVI-array round-robin collector:
//   N_CH_DEF / WIDTH_DEF : default channel count and data width
//   ch_width()           : width of a channel index, never less than 1 bit
//   ch_idx_t             : channel index type for the default channel count
// ---------------------------------------------------------------------------
package svi_collect_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int WIDTH_DEF = 8;

    // A single channel still needs a 1-bit index so o_ch has a legal width.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W_DEF = ch_width(N_CH_DEF);

    typedef logic [CH_W_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/svi_array_rr_collector_if.sv
// ---------------------------------------------------------------------------
// I_stream
// One per-channel valid/ready stream.
//   valid, data : driven by the producer (master)
//   ready       : driven by the collector (slave)
// Parameter WIDTH sets the data width.
// ---------------------------------------------------------------------------
interface I_stream
    import svi_collect_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/svi_array_rr_collector_arb.sv
// ---------------------------------------------------------------------------
// svi_rr_arb
// Purely combinational round-robin arbiter. The search starts at ptr and
// wraps from N_CH-1 back to 0; the first requesting channel wins.
// The pointer register lives in the parent.
// Ports:
//   req       [N_CH-1:0]  request vector
//   ptr       [CH_W-1:0]  highest-priority index (must be < N_CH)
//   grant     [N_CH-1:0]  one-hot grant (all zero when no request)
//   grant_idx [CH_W-1:0]  index of the granted channel
//   any_req               at least one request present
// ---------------------------------------------------------------------------
module svi_rr_arb
    import svi_collect_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_req
);

    logic            found;
    logic [CH_W:0]   idx_w;
    logic [CH_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_w     = '0;
        idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            // ptr + i is at most 2*N_CH-2, so one subtraction wraps it.
            idx_w = {1'b0, ptr} + (CH_W+1)'(i);
            if (idx_w >= (CH_W+1)'(N_CH)) begin
                idx_w = idx_w - (CH_W+1)'(N_CH);
            end
            idx = idx_w[CH_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/svi_array_rr_collector.sv
// ---------------------------------------------------------------------------
// svi_array_rr_collector
// Buffers one beat per input channel and merges all channels round-robin
// into a single registered output stream tagged with the source channel.
// Optional build macro: SVI_COLLECT_CNT_EN adds saturating per-channel
// counters of beats accepted downstream (port o_cnt).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   u_I[N_CH]      per-channel streams (slave side)
//   i_ready        downstream ready
//   o_valid/o_data/o_ch  registered output beat and its source channel
//   o_cnt          (SVI_COLLECT_CNT_EN only) accepted-beat counters
// ---------------------------------------------------------------------------
module svi_array_rr_collector
    import svi_collect_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    I_stream.slave                      u_I [N_CH-1:0],
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_data,
    output logic [ch_width(N_CH)-1:0]   o_ch
`ifdef SVI_COLLECT_CNT_EN
    ,
    output logic [N_CH-1:0][CNT_W-1:0]  o_cnt
`endif
);

    localparam int CH_W = ch_width(N_CH);

    if (N_CH < 1 || N_CH > 32 || WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("svi_array_rr_collector: illegal N_CH, WIDTH or CNT_W");
    end

    logic [N_CH-1:0]  in_valid;
    logic [N_CH-1:0]  in_ready;
    logic [WIDTH-1:0] in_data [N_CH];
    logic [N_CH-1:0]  capture;

    logic [N_CH-1:0]  hold_v_reg;
    logic [WIDTH-1:0] hold_d_reg [N_CH];

    logic [N_CH-1:0]  grant_raw;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic             any_req;
    logic             out_adv;

    logic [CH_W-1:0]  ptr_reg;
    logic [CH_W-1:0]  ptr_next;
    logic             o_valid_reg;
    logic [WIDTH-1:0] o_data_reg;
    logic [CH_W-1:0]  o_ch_reg;

    assign out_adv = ~o_valid_reg | i_ready;
    // A channel is only granted when the output register can take the beat.
    assign grant   = grant_raw & {N_CH{out_adv}};
    // Ready while empty, or while the held beat leaves this cycle so a
    // single uncontended channel can stream at one beat per cycle.
    assign in_ready = {N_CH{~i_rst}} & (~hold_v_reg | grant);
    assign capture  = in_valid & in_ready;

    svi_rr_arb #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req       (hold_v_reg),
        .ptr       (ptr_reg),
        .grant     (grant_raw),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign in_valid[gi]    = u_I[gi].valid;
        assign in_data[gi]     = u_I[gi].data;
        assign u_I[gi].ready   = in_ready[gi];

        // A refill takes precedence over the grant-driven clear.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                hold_v_reg[gi] <= 1'b0;
                hold_d_reg[gi] <= '0;
            end else if (capture[gi]) begin
                hold_v_reg[gi] <= 1'b1;
                hold_d_reg[gi] <= in_data[gi];
            end else if (grant[gi]) begin
                hold_v_reg[gi] <= 1'b0;
            end
        end
    end

    assign ptr_next = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid_reg <= 1'b0;
            o_data_reg  <= '0;
            o_ch_reg    <= '0;
            ptr_reg     <= '0;
        end else if (out_adv) begin
            if (any_req) begin
                o_valid_reg <= 1'b1;
                o_data_reg  <= hold_d_reg[grant_idx];
                o_ch_reg    <= grant_idx;
                ptr_reg     <= ptr_next;
            end else begin
                // Data and channel keep their last values while idle.
                o_valid_reg <= 1'b0;
            end
        end
    end

    assign o_valid = o_valid_reg;
    assign o_data  = o_data_reg;
    assign o_ch    = o_ch_reg;

`ifdef SVI_COLLECT_CNT_EN
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cnt_reg <= '0;
            end else if (o_valid_reg && i_ready && (o_ch_reg == CH_W'(gi))
                         && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign o_cnt[gi] = cnt_reg;
    end
`endif

endmodule
